// File: rtl/quinta_pkg.sv
// rtl/quinta_pkg.sv - shared types for the register-file write arbiter
package quinta_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SHARE,
    ARB_DRAIN
  } arb_state_t;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// rtl/regfile_write_arbiter_fifo.sv - LU result queue with per-entry valid/rd taps
module wb_result_fifo
  import quinta_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_req_t                       push_req,
  input  logic                          pop,
  output wb_req_t                       head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][REG_W-1:0]   ent_rd
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t      mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ent_valid <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr                       <= rd_ptr + (AW+1)'(1);
        ent_valid[rd_ptr[AW-1:0]]    <= 1'b0;
      end
      if (do_push) begin
        wr_ptr                       <= wr_ptr + (AW+1)'(1);
        ent_valid[wr_ptr[AW-1:0]]    <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i] = mem[i].rd;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the RF write port between WB and a long-latency unit
module regfile_write_arbiter
  import quinta_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic              pipe_we,
  input  logic [REG_W-1:0]  pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_W-1:0]  lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  output logic              stall_req,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       pending_mask
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  arb_state_t                        state;
  arb_state_t                        state_nxt;
  logic [CW-1:0]                     starve_cnt;
  logic [CW-1:0]                     starve_nxt;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic [AW:0]                       fifo_count;
  logic [FIFO_DEPTH-1:0]             ent_valid;
  logic [FIFO_DEPTH-1:0][REG_W-1:0]  ent_rd;
  wb_req_t                           head;
  wb_req_t                           push_req;
  wb_req_t                           sel_req;
  logic                              sel_we;
  logic                              push;
  logic                              pop;
  logic                              pipe_req;
  logic                              last_pop;

  assign lu_ready      = ~fifo_full;
  assign push          = lu_valid & lu_ready & (lu_rd != '0);
  assign push_req.rd   = lu_rd;
  assign push_req.data = lu_data;
  assign stall_req     = (state == ARB_DRAIN);
  assign pipe_req      = pipe_valid & pipe_we & (pipe_rd != '0) & ~stall_req;
  assign last_pop      = pop & ~push & (fifo_count == (AW+1)'(1));

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_req  (push_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  always_comb begin
    pop = 1'b0;
    case (state)
      ARB_SHARE: pop = ~pipe_req & ~fifo_empty;
      ARB_DRAIN: pop = ~fifo_empty;
      default:   pop = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = '0;
    case (state)
      ARB_IDLE: begin
        if (push) state_nxt = ARB_SHARE;
      end
      ARB_SHARE: begin
        if (!pop) begin
          starve_nxt = (starve_cnt == CW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + CW'(1);
        end
        if (last_pop) begin
          state_nxt = ARB_IDLE;
        end else if ((!pop && starve_cnt == CW'(STARVE_LIMIT - 1)) || (fifo_full && lu_valid)) begin
          state_nxt = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        if (last_pop || fifo_empty) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Pipeline has priority; pop only happens when the pipeline is not writing.
  always_comb begin
    sel_we  = 1'b0;
    sel_req = '0;
    if (pipe_req) begin
      sel_we       = 1'b1;
      sel_req.rd   = pipe_rd;
      sel_req.data = pipe_data;
    end else if (pop) begin
      sel_we  = 1'b1;
      sel_req = head;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i]) pending_mask[ent_rd[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      rf_we      <= sel_we;
      rf_waddr   <= sel_req.rd;
      rf_wdata   <= sel_req.data;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, pipe_we, lu_valid, lu_ready, stall_req, rf_we;
  logic [4:0]  pipe_rd, lu_rd, rf_waddr;
  logic [31:0] pipe_data, lu_data, rf_wdata, pending_mask;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_valid   (pipe_valid),
    .pipe_we      (pipe_we),
    .pipe_rd      (pipe_rd),
    .pipe_data    (pipe_data),
    .lu_valid     (lu_valid),
    .lu_ready     (lu_ready),
    .lu_rd        (lu_rd),
    .lu_data      (lu_data),
    .stall_req    (stall_req),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pending_mask (pending_mask)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        pv;
    logic        pwe;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exp_we;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[6];
  int   checks   = 0;
  int   failures = 0;
  logic prev_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic mon();
    wr_t e;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rf_unexpected actual=x%0d/0x%0h required=no_write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("rf_waddr", 32'(rf_waddr), 32'(e.rd));
        chk("rf_wdata", rf_wdata, e.data);
      end
    end
  endtask

  task automatic idle_in();
    pipe_valid = 1'b0; pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_valid   = 1'b0; lu_rd   = '0;   lu_data = '0;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
    pipe_valid = 1'b1; pipe_we = 1'b1; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic lu(input logic [4:0] rd, input logic [31:0] d);
    lu_valid = 1'b1; lu_rd = rd; lu_data = d;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    wr_t e;
    e.rd = rd; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic half();
    @(negedge clk);
    mon();
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 5'd0,  32'h12345678, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 5'd3,  32'h00000033, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 5'd4,  32'h00000044, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 5'd1,  32'h00000001, 1'b1};

    rst = 1'b0;
    idle_in();
    fin(); fin();
    half();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("rst_mask", pending_mask, 32'd0);
    rst = 1'b1;
    fin();

    // pipeline-only vectors
    prev_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pipe_valid = vecs[i].pv; pipe_we = vecs[i].pwe;
      pipe_rd = vecs[i].rd; pipe_data = vecs[i].data;
      if (vecs[i].exp_we) expect_wr(vecs[i].rd, vecs[i].data);
      half();
      chk("tbl_rf_we", 32'(rf_we), 32'(prev_we));
      chk("tbl_stall", 32'(stall_req), 32'd0);
      prev_we = vecs[i].exp_we;
      fin();
    end
    idle_in();
    half();
    chk("tbl_rf_we", 32'(rf_we), 32'(prev_we));
    fin();

    // LU result for x0 is accepted and dropped
    lu(5'd0, 32'h55);
    half(); chk("x0_lu_ready", 32'(lu_ready), 32'd1); fin();
    idle_in();
    half(); chk("x0_mask", pending_mask, 32'd0); chk("x0_rf_we", 32'(rf_we), 32'd0); fin();
    half(); chk("x0_rf_we2", 32'(rf_we), 32'd0); fin();

    // bubble drain
    lu(5'd7, 32'h11);
    half(); chk("bub_mask0", pending_mask, 32'd0); fin();
    idle_in();
    expect_wr(5'd7, 32'h11);
    half(); chk("bub_mask7", pending_mask, 32'h80); chk("bub_stall", 32'(stall_req), 32'd0); fin();
    half(); chk("bub_mask_clr", pending_mask, 32'd0); fin();

    // starvation: x9 waits through four pipe writes, fifth is held by the stall
    lu(5'd9, 32'h99);
    half(); chk("stv_lu_ready", 32'(lu_ready), 32'd1); fin();
    lu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pipe(5'(10 + i), 32'hA0 + 32'(i));
      expect_wr(5'(10 + i), 32'hA0 + 32'(i));
      half();
      chk("stv_no_stall", 32'(stall_req), 32'd0);
      chk("stv_mask9", pending_mask, 32'h200);
      fin();
    end
    pipe(5'd14, 32'hA4);
    expect_wr(5'd9, 32'h99);
    half(); chk("stv_stall", 32'(stall_req), 32'd1); fin();
    expect_wr(5'd14, 32'hA4);
    half(); chk("stv_stall_drop", 32'(stall_req), 32'd0); chk("stv_mask_clr", pending_mask, 32'd0); fin();
    idle_in();
    half(); fin();

    // full FIFO forces a drain; x3 waits for a free slot
    pipe(5'd20, 32'h20); lu(5'd1, 32'h101); expect_wr(5'd20, 32'h20);
    half(); chk("full_rdy0", 32'(lu_ready), 32'd1); fin();
    pipe(5'd21, 32'h21); lu(5'd2, 32'h102); expect_wr(5'd21, 32'h21);
    half(); chk("full_rdy1", 32'(lu_ready), 32'd1); chk("full_mask1", pending_mask, 32'h2); fin();
    pipe(5'd22, 32'h22); lu(5'd3, 32'h103); expect_wr(5'd22, 32'h22);
    half();
    chk("full_rdy2", 32'(lu_ready), 32'd0);
    chk("full_mask12", pending_mask, 32'h6);
    chk("full_nostall", 32'(stall_req), 32'd0);
    fin();
    pipe(5'd23, 32'h23); expect_wr(5'd1, 32'h101);
    half(); chk("drn_stall0", 32'(stall_req), 32'd1); chk("drn_rdy_blk", 32'(lu_ready), 32'd0); fin();
    expect_wr(5'd2, 32'h102);
    half(); chk("drn_stall1", 32'(stall_req), 32'd1); chk("drn_rdy_free", 32'(lu_ready), 32'd1); fin();
    lu_valid = 1'b0; expect_wr(5'd3, 32'h103);
    half(); chk("drn_stall2", 32'(stall_req), 32'd1); chk("drn_mask3", pending_mask, 32'h8); fin();
    expect_wr(5'd23, 32'h23);
    half(); chk("drn_exit", 32'(stall_req), 32'd0); fin();
    idle_in();
    half(); fin();

    // reset while draining a full FIFO
    pipe(5'd24, 32'h24); lu(5'd4, 32'h104); expect_wr(5'd24, 32'h24);
    half(); fin();
    pipe(5'd25, 32'h25); lu(5'd5, 32'h105); expect_wr(5'd25, 32'h25);
    half(); fin();
    pipe(5'd26, 32'h26); lu(5'd6, 32'h106); expect_wr(5'd26, 32'h26);
    half(); fin();
    idle_in();
    rst = 1'b0;
    half(); chk("mrst_pre_stall", 32'(stall_req), 32'd1); fin();
    rst = 1'b1;
    half();
    chk("mrst_rf_we", 32'(rf_we), 32'd0);
    chk("mrst_stall", 32'(stall_req), 32'd0);
    chk("mrst_lu_ready", 32'(lu_ready), 32'd1);
    chk("mrst_mask", pending_mask, 32'd0);
    fin();
    half(); chk("mrst_rf_we2", 32'(rf_we), 32'd0); fin();
    half(); fin();

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
